// File: rtl/deg_to_rad_seq.sv
// Sequential degree-to-radian converter: optional modulo-360 fold via a
// restoring divider, then a serial shift-add multiply by pi/180 in Q3.(OUT_W-3).
module deg_to_rad_seq #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32,
  parameter int WRAP  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  deg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] rad,
  output logic                    range_err
);

  // K = round(pi/180 * 2^(OUT_W-3)) derived from pi in Q2.61 to stay in integer arithmetic
  localparam logic [63:0]    PI_Q61   = 64'h6487_ED51_10B4_611A;
  localparam logic [63:0]    PI_DEG   = PI_Q61 / 64'd180;
  localparam int             SH       = 64 - OUT_W;
  localparam logic [63:0]    K_FULL   = (PI_DEG + (64'd1 << (SH - 1))) >> SH;
  localparam logic [OUT_W:0] K        = K_FULL[OUT_W:0];
  localparam logic [IN_W-1:0] MAG_MAX = IN_W'(180);
  localparam logic [6:0]     DIV_LAST = 7'(IN_W - 1);
  localparam logic [6:0]     MUL_LAST = 7'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_DIV, S_CHECK, S_FOLD, S_MUL, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             r_sign_q, r_sign_d;
  logic [IN_W-1:0]  mag_q, mag_d;
  logic [8:0]       r_q, r_d;
  logic [OUT_W:0]   acc_q, acc_d;
  logic [OUT_W:0]   add_q, add_d;
  logic [OUT_W-1:0] rad_q, rad_d;
  logic             range_err_q, range_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [IN_W-1:0]  deg_u;
  logic [IN_W-1:0]  deg_abs;
  logic [9:0]       rem_shift;
  logic [8:0]       r_neg;

  // Next-state, datapath and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    r_sign_d    = r_sign_q;
    mag_d       = mag_q;
    r_d         = r_q;
    acc_d       = acc_q;
    add_d       = add_q;
    rad_d       = rad_q;
    range_err_d = range_err_q;
    deg_u       = deg;
    deg_abs     = deg_u[IN_W-1] ? (~deg_u + IN_W'(1)) : deg_u;
    rem_shift   = {r_q, mag_q[IN_W-1]};
    r_neg       = 9'd0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d      = deg_u[IN_W-1];
          mag_d       = deg_abs;
          r_d         = 9'd0;
          acc_d       = '0;
          cnt_d       = 7'd0;
          range_err_d = 1'b0;
          state_d     = (WRAP != 0) ? S_DIV : S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        mag_d = mag_q << 1;
        r_d   = 9'((rem_shift >= 10'd360) ? (rem_shift - 10'd360) : rem_shift);
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == DIV_LAST) begin
          state_d = S_FOLD;
        end else begin
          state_d = S_DIV;
        end
      end
      S_CHECK: begin
        if (mag_q > MAG_MAX) begin
          range_err_d = 1'b1;
          r_d         = 9'd0;
          rad_d       = '0;
          state_d     = S_DONE;
        end else begin
          r_d      = mag_q[8:0];
          r_sign_d = sign_q;
          add_d    = K;
          acc_d    = '0;
          cnt_d    = 7'd0;
          state_d  = S_MUL;
        end
      end
      S_FOLD: begin
        // Negative angles become 360-r, then the upper half maps to -(360-r)
        r_neg = (sign_q && (r_q != 9'd0)) ? (9'd360 - r_q) : r_q;
        if (r_neg >= 9'd180) begin
          r_d      = 9'd360 - r_neg;
          r_sign_d = 1'b1;
        end else begin
          r_d      = r_neg;
          r_sign_d = 1'b0;
        end
        add_d   = K;
        acc_d   = '0;
        cnt_d   = 7'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        if (r_q[0]) begin
          acc_d = acc_q + add_q;
        end else begin
          acc_d = acc_q;
        end
        add_d = add_q << 1;
        r_d   = r_q >> 1;
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == MUL_LAST) begin
          rad_d   = r_sign_q ? (OUT_W'(0) - acc_d[OUT_W-1:0]) : acc_d[OUT_W-1:0];
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      sign_q      <= 1'b0;
      r_sign_q    <= 1'b0;
      mag_q       <= '0;
      r_q         <= 9'd0;
      acc_q       <= '0;
      add_q       <= '0;
      rad_q       <= '0;
      range_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      r_sign_q    <= r_sign_d;
      mag_q       <= mag_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      add_q       <= add_d;
      rad_q       <= rad_d;
      range_err_q <= range_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign rad       = rad_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_deg_to_rad_seq.sv
// Scoreboard bench for deg_to_rad_seq: one WRAP=1 and one WRAP=0 instance,
// expected results queued at accept time and checked by per-instance monitors.
module tb_deg_to_rad_seq;

  localparam longint K_B = 64'd9370165;

  typedef struct {
    logic [31:0] rad;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;

  logic        v1, rdy1, ov1, ordy1, err1;
  logic [31:0] d1, rad1;
  logic        v0, rdy0, ov0, ordy0, err0;
  logic [31:0] d0, rad0;

  exp_t q1[$];
  exp_t q0[$];

  deg_to_rad_seq #(.IN_W(32), .OUT_W(32), .WRAP(1)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(v1), .in_ready(rdy1), .deg(d1),
    .out_valid(ov1), .out_ready(ordy1), .rad(rad1), .range_err(err1)
  );

  deg_to_rad_seq #(.IN_W(32), .OUT_W(32), .WRAP(0)) dut_nowrap (
    .clk(clk), .reset_n(reset_n), .in_valid(v0), .in_ready(rdy0), .deg(d0),
    .out_valid(ov0), .out_ready(ordy0), .rad(rad0), .range_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wrapped-angle model: reduce into [-180,180) with signed remainder arithmetic
  function automatic logic [31:0] model(input longint d);
    longint m;
    m = d % 360;
    if (m < 0) m = m + 360;
    if (m >= 180) m = m - 360;
    return 32'(m * K_B);
  endfunction

  task automatic drive(input int which, input longint d, input logic [31:0] er,
                       input logic ee, input int lat);
    exp_t e;
    logic ok;
    ok = 1'b0;
    if (which == 1) begin v1 = 1'b1; d1 = 32'(d); end
    else begin v0 = 1'b1; d0 = 32'(d); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 1) ? rdy1 : rdy0) begin
        e.rad = er; e.err = ee; e.cyc = cyc + 1 + lat;
        if (which == 1) q1.push_back(e); else q0.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    check("accept_in_time", ok, 1);
    @(posedge clk); #1;
    if (which == 1) v1 = 1'b0; else v0 = 1'b0;
  endtask

  task automatic wait_drain(input int which);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 1) ? (q1.size() == 0 && !ov1) : (q0.size() == 0 && !ov0)) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_in_time", ok, 1);
    @(posedge clk); #1;
  endtask

  // Monitor for the wrapping instance
  always @(negedge clk) begin : mon1
    exp_t e;
    logic        ov_p;
    logic [31:0] rad_p;
    logic        err_p;
    if (ov1 && ov_p) begin
      check("w_hold_rad", rad1, rad_p);
      check("w_hold_err", err1, err_p);
    end
    if (ov1 && !ov_p) begin
      if (q1.size() == 0) check("w_spurious_out", ov1, 0);
      else check("w_latency", cyc, q1[0].cyc);
    end
    if (ov1 && ordy1 && q1.size() != 0) begin
      e = q1.pop_front();
      check("w_rad", rad1, e.rad);
      check("w_err", err1, e.err);
    end
    ov_p  = ov1;
    rad_p = rad1;
    err_p = err1;
  end

  // Monitor for the non-wrapping instance
  always @(negedge clk) begin : mon0
    exp_t e;
    logic ov_p;
    if (ov0 && !ov_p) begin
      if (q0.size() == 0) check("n_spurious_out", ov0, 0);
      else check("n_latency", cyc, q0[0].cyc);
    end
    if (ov0 && ordy0 && q0.size() != 0) begin
      e = q0.pop_front();
      check("n_rad", rad0, e.rad);
      check("n_err", err0, e.err);
    end
    ov_p = ov0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   stale;
    logic seen;
    cyc = 0; checks = 0; errors = 0;
    v1 = 1'b0; d1 = 32'd0; ordy1 = 1'b1;
    v0 = 1'b0; d0 = 32'd0; ordy0 = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", rdy1, 1);
    check("rst_out_valid", ov1, 0);
    check("rst_rad", rad1, 0);
    check("rst_err", err1, 0);
    check("rst_n_in_ready", rdy0, 1);
    check("rst_n_rad", rad0, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Wrapped conversions
    drive(1, 90, 32'h3243F6A2, 1'b0, 42);
    drive(1, 45, 32'h1921FB51, 1'b0, 42);
    drive(1, 0, 32'h00000000, 1'b0, 42);
    drive(1, 450, 32'h3243F6A2, 1'b0, 42);
    drive(1, -270, 32'h3243F6A2, 1'b0, 42);
    drive(1, -90, 32'hCDBC095E, 1'b0, 42);
    drive(1, 180, 32'h9B7812BC, 1'b0, 42);
    drive(1, -64'sd2147483648, model(-64'sd2147483648), 1'b0, 42);
    wait_drain(1);

    // Range checking without wrap
    drive(0, 180, 32'h6487ED44, 1'b0, 10);
    drive(0, 181, 32'h00000000, 1'b1, 1);
    drive(0, -180, 32'h9B7812BC, 1'b0, 10);
    drive(0, -181, 32'h00000000, 1'b1, 1);
    drive(0, 0, 32'h00000000, 1'b0, 10);
    drive(0, 100000, 32'h00000000, 1'b1, 1);
    wait_drain(0);

    // Backpressure with in_valid toggling while the result is held
    ordy1 = 1'b0;
    drive(1, 30, model(30), 1'b0, 42);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ov1) begin seen = 1'b1; break; end
    end
    check("bp_valid_seen", seen, 1);
    d1 = 32'd77;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 v1 = ~v1;
      @(negedge clk);
      check("bp_in_ready_low", rdy1, 0);
    end
    @(posedge clk); #1 v1 = 1'b0; ordy1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_in_ready_after", rdy1, 1);
    wait_drain(1);

    // Back-to-back stream
    drive(1, 15, model(15), 1'b0, 42);
    drive(1, 30, model(30), 1'b0, 42);
    drive(1, -45, 32'hE6DE04AF, 1'b0, 42);
    drive(1, 83, model(83), 1'b0, 42);
    wait_drain(1);

    // Reset in the middle of the division
    drive(1, 1000, model(1000), 1'b0, 42);
    repeat (10) @(posedge clk);
    #2;
    q1.delete();
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", ov1, 0);
    check("midrst_in_ready", rdy1, 1);
    check("midrst_rad", rad1, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ov1) stale++;
    end
    check("midrst_no_stale", stale, 0);
    @(posedge clk); #1;
    drive(1, 720, 32'h00000000, 1'b0, 42);
    drive(1, -90, 32'hCDBC095E, 1'b0, 42);
    wait_drain(1);

    check("q_wrap_empty", q1.size(), 0);
    check("q_nowrap_empty", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
